l2_memory_responder: RTL and testbench

- Responder end of the core's L2 requester port: accepts queued read/write requests and burst write data, services them from an internal single-port synchronous RAM, and returns read data with a valid/ack handshake.
- Sits outside the core as the L2 target, for simulation benches and small FPGA systems without an external L2/DRAM.
- Requests are serviced strictly in arrival order; one request is in service at a time.

---
 rtl/l2_responder_types.sv | 21 ++
 rtl/l2_responder_fifo.sv | 57 +++++
 rtl/l2_memory_responder.sv | 159 +++++++++++++++
 tb/tb_l2_memory_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_responder_types.sv
// Shared types for the L2 memory responder: queued request word and FSM states.
package l2_responder_types;

    localparam int L2_SUB_ID_MAX_W = 8;

    typedef struct packed {
        logic [29:0]                addr;
        logic                       rnw;
        logic [3:0]                 be;
        logic [4:0]                 burst_size;
        logic [L2_SUB_ID_MAX_W-1:0] sub_id;
    } l2_request_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DRAIN
    } l2_state_t;

endpackage

// File: rtl/l2_responder_fifo.sv
// Count-based FIFO with registered full flag and sticky overflow on dropped pushes.
module l2_responder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count, count_next;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still accepted when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            full     <= (count_next == (PW+1)'(DEPTH));
            overflow <= overflow | (push && !do_push);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/l2_memory_responder.sv
// L2 target backed by an internal single-port RAM; services queued read/write bursts in order.
//  state    | meaning
//  ST_IDLE  | pop next request into active registers
//  ST_WRITE | commit one write beat per available data word
//  ST_READ  | issue RAM reads while the 2-entry output buffer has credit
//  ST_DRAIN | wait for the last read of the burst to land in the buffer
module l2_memory_responder
    import l2_responder_types::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int REQ_DEPTH = 4,
    parameter int WR_DEPTH  = 16,
    parameter int SUB_ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [29:0]         addr,
    input  logic                rnw,
    input  logic [3:0]          be,
    input  logic [4:0]          burst_size,
    input  logic [SUB_ID_W-1:0] sub_id,
    input  logic                request_push,
    output logic                request_full,
    input  logic [31:0]         wr_data,
    input  logic                wr_data_push,
    output logic                data_full,
    output logic [31:0]         rd_data,
    output logic [SUB_ID_W-1:0] rd_sub_id,
    output logic                rd_data_valid,
    input  logic                rd_data_ack,
    output logic                overflow_error
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    l2_request_t         req_in, req_head;
    logic                req_empty, req_ovf, req_pop;
    logic [31:0]         wd_dout;
    logic                wd_empty, wd_ovf, wd_pop;

    l2_state_t           state;
    logic [IDX_W-1:0]    act_idx;
    logic [3:0]          act_be;
    logic [5:0]          beats;
    logic [SUB_ID_W-1:0] act_sub_id;

    logic [31:0]         mem [MEM_WORDS];
    logic [31:0]         ram_q;
    logic                rd_pend;
    logic [SUB_ID_W-1:0] rd_pend_id;
    logic                rd_issue, out_pop;
    logic [1:0]          used, buf_cnt;
    logic [31:0]         buf_data1;
    logic [SUB_ID_W-1:0] buf_id1;
    logic                unused_req_bits;

    assign req_in = '{addr: addr, rnw: rnw, be: be, burst_size: burst_size,
                      sub_id: L2_SUB_ID_MAX_W'(sub_id)};
    assign unused_req_bits = ^{req_head.addr[29:IDX_W], req_head.sub_id};

    l2_responder_fifo #(.DEPTH(REQ_DEPTH), .WIDTH($bits(l2_request_t))) u_req_fifo (
        .clk(clk), .rst(rst), .push(request_push), .pop(req_pop), .din(req_in),
        .dout(req_head), .empty(req_empty), .full(request_full), .overflow(req_ovf)
    );

    l2_responder_fifo #(.DEPTH(WR_DEPTH), .WIDTH(32)) u_wd_fifo (
        .clk(clk), .rst(rst), .push(wr_data_push), .pop(wd_pop), .din(wr_data),
        .dout(wd_dout), .empty(wd_empty), .full(data_full), .overflow(wd_ovf)
    );

    assign overflow_error = req_ovf | wd_ovf;
    assign rd_data_valid  = (buf_cnt != 2'd0);
    assign out_pop        = rd_data_valid && rd_data_ack;
    assign req_pop        = (state == ST_IDLE) && !req_empty;
    assign wd_pop         = (state == ST_WRITE) && !wd_empty;
    // A beat leaving the buffer this cycle frees a slot for a new issue.
    assign used           = {1'b0, rd_pend} + buf_cnt;
    assign rd_issue       = (state == ST_READ) && ((used < 2'd2) || out_pop);

    always_ff @(posedge clk) begin
        if (wd_pop) begin
            for (int b = 0; b < 4; b++)
                if (act_be[b]) mem[act_idx][8*b +: 8] <= wd_dout[8*b +: 8];
        end
        if (rd_issue) ram_q <= mem[act_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            act_idx    <= '0;
            act_be     <= '0;
            beats      <= '0;
            act_sub_id <= '0;
            rd_pend    <= 1'b0;
            rd_pend_id <= '0;
            buf_cnt    <= 2'd0;
            rd_data    <= '0;
            rd_sub_id  <= '0;
            buf_data1  <= '0;
            buf_id1    <= '0;
        end else begin
            rd_pend    <= rd_issue;
            rd_pend_id <= act_sub_id;

            case (state)
                ST_IDLE: if (req_pop) begin
                    act_idx    <= req_head.addr[IDX_W-1:0];
                    act_be     <= req_head.be;
                    beats      <= {1'b0, req_head.burst_size} + 6'd1;
                    act_sub_id <= req_head.sub_id[SUB_ID_W-1:0];
                    state      <= req_head.rnw ? ST_READ : ST_WRITE;
                end
                ST_WRITE: if (wd_pop) begin
                    act_idx <= act_idx + 1'b1;
                    beats   <= beats - 6'd1;
                    if (beats == 6'd1) state <= ST_IDLE;
                end
                ST_READ: if (rd_issue) begin
                    act_idx <= act_idx + 1'b1;
                    beats   <= beats - 6'd1;
                    if (beats == 6'd1) state <= ST_DRAIN;
                end
                ST_DRAIN: if (!rd_pend) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            case ({rd_pend, out_pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        rd_data   <= ram_q;
                        rd_sub_id <= rd_pend_id;
                    end else begin
                        buf_data1 <= ram_q;
                        buf_id1   <= rd_pend_id;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    rd_data   <= buf_data1;
                    rd_sub_id <= buf_id1;
                    buf_cnt   <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        rd_data   <= ram_q;
                        rd_sub_id <= rd_pend_id;
                    end else begin
                        rd_data   <= buf_data1;
                        rd_sub_id <= buf_id1;
                        buf_data1 <= ram_q;
                        buf_id1   <= rd_pend_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_memory_responder.sv
// Directed bench for l2_memory_responder with hand-computed expected beats.
module tb_l2_memory_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [4:0]  burst_size;
    logic [1:0]  sub_id;
    logic        request_push;
    logic        request_full;
    logic [31:0] wr_data;
    logic        wr_data_push;
    logic        data_full;
    logic [31:0] rd_data;
    logic [1:0]  rd_sub_id;
    logic        rd_data_valid;
    logic        rd_data_ack;
    logic        overflow_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cap_data [32];
    logic [1:0]  cap_id   [32];
    int          cap_cyc  [32];
    int          cap_n;
    logic        ack_pat  [16];
    int          ack_len;

    always #5 clk = ~clk;

    l2_memory_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .rnw(rnw), .be(be), .burst_size(burst_size),
        .sub_id(sub_id), .request_push(request_push), .request_full(request_full),
        .wr_data(wr_data), .wr_data_push(wr_data_push), .data_full(data_full),
        .rd_data(rd_data), .rd_sub_id(rd_sub_id), .rd_data_valid(rd_data_valid),
        .rd_data_ack(rd_data_ack), .overflow_error(overflow_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_req(input logic [29:0] a, input logic r, input logic [3:0] b,
                            input logic [4:0] bs, input logic [1:0] id);
        addr = a; rnw = r; be = b; burst_size = bs; sub_id = id;
        request_push = 1'b1;
        @(negedge clk);
        request_push = 1'b0;
    endtask

    task automatic push_wd(input logic [31:0] d);
        wr_data = d;
        wr_data_push = 1'b1;
        @(negedge clk);
        wr_data_push = 1'b0;
    endtask

    // Consumes n beats; ack follows ack_pat per valid cycle, then stays high.
    task automatic collect(input int n, input int budget);
        int cyc = 0;
        int pidx = 0;
        logic pv = 1'b0;
        logic pa = 1'b0;
        logic [31:0] pd = '0;
        cap_n = 0;
        while (cap_n < n && cyc < budget) begin
            rd_data_ack = (pidx < ack_len) ? ack_pat[pidx] : 1'b1;
            if (pv && !pa) chk("stall_stable", rd_data, pd);
            if (rd_data_valid) begin
                pidx++;
                if (rd_data_ack) begin
                    cap_data[cap_n] = rd_data;
                    cap_id[cap_n]   = rd_sub_id;
                    cap_cyc[cap_n]  = cyc;
                    cap_n++;
                end
            end
            pv = rd_data_valid; pa = rd_data_ack; pd = rd_data;
            @(negedge clk);
            cyc++;
        end
        rd_data_ack = 1'b0;
        ack_len = 0;
        if (cap_n < n) chk("collect_timeout", cap_n, n);
    endtask

    initial begin
        int lat;
        int extra;
        rst = 1'b0; addr = '0; rnw = 1'b0; be = '0; burst_size = '0; sub_id = '0;
        request_push = 1'b0; wr_data = '0; wr_data_push = 1'b0; rd_data_ack = 1'b0;
        ack_len = 0;
        tick(3);
        chk("rst_valid", rd_data_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sub_id", rd_sub_id, 0);
        chk("rst_req_full", request_full, 0);
        chk("rst_data_full", data_full, 0);
        chk("rst_ovf", overflow_error, 0);
        rst = 1'b1;
        tick(2);

        // single write then read with latency check
        push_req(30'h10, 1'b0, 4'hF, 5'd0, 2'd0);
        push_wd(32'hDEADBEEF);
        tick(4);
        push_req(30'h10, 1'b1, 4'hF, 5'd0, 2'd2);
        lat = 0;
        while (!rd_data_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("first_latency", lat, 3);
        collect(1, 20);
        chk("single_data", cap_data[0], 32'hDEADBEEF);
        chk("single_id", cap_id[0], 2);

        // write burst with data ahead of request, then full-rate read
        for (int i = 0; i < 8; i++) push_wd(i);
        tick(5);
        push_req(30'h100, 1'b0, 4'hF, 5'd7, 2'd0);
        tick(12);
        push_req(30'h100, 1'b1, 4'hF, 5'd7, 2'd1);
        collect(8, 40);
        for (int i = 0; i < 8; i++) chk($sformatf("burst8_d%0d", i), cap_data[i], i);
        chk("burst8_id", cap_id[7], 1);
        chk("burst8_no_bubble", cap_cyc[7] - cap_cyc[0], 7);

        // stalled read with ack pattern 1,0,0,1,1,0,1
        ack_pat[0] = 1; ack_pat[1] = 0; ack_pat[2] = 0; ack_pat[3] = 1;
        ack_pat[4] = 1; ack_pat[5] = 0; ack_pat[6] = 1;
        push_req(30'h104, 1'b1, 4'hF, 5'd3, 2'd3);
        ack_len = 7;
        collect(4, 40);
        for (int i = 0; i < 4; i++) chk($sformatf("stall_d%0d", i), cap_data[i], 4 + i);
        tick(5);
        chk("stall_no_extra", rd_data_valid, 0);

        // byte enables
        push_req(30'h20, 1'b0, 4'hF, 5'd0, 2'd0);
        push_wd(32'hFFFFFFFF);
        push_req(30'h20, 1'b0, 4'b0101, 5'd0, 2'd0);
        push_wd(32'h00000000);
        tick(6);
        push_req(30'h20, 1'b1, 4'hF, 5'd0, 2'd1);
        collect(1, 20);
        chk("be_mask", cap_data[0], 32'hFF00FF00);

        // wrap around the top of memory; upper address bits ignored
        push_req(30'h1000_0FFE, 1'b0, 4'hF, 5'd3, 2'd0);
        for (int i = 0; i < 4; i++) push_wd(32'hA0 + i);
        tick(4);
        push_req(30'hFFE, 1'b1, 4'hF, 5'd1, 2'd1);
        collect(2, 20);
        chk("wrap_ffe", cap_data[0], 32'hA0);
        chk("wrap_fff", cap_data[1], 32'hA1);
        push_req(30'h0, 1'b1, 4'hF, 5'd1, 2'd1);
        collect(2, 20);
        chk("wrap_000", cap_data[0], 32'hA2);
        chk("wrap_001", cap_data[1], 32'hA3);

        // overflow: block the FSM on a write with no data, then overfill requests
        push_req(30'h300, 1'b0, 4'hF, 5'd0, 2'd0);
        tick(2);
        for (int i = 0; i < 3; i++) push_req(30'h10, 1'b1, 4'hF, 5'd0, 2'd1);
        chk("full_after3", request_full, 0);
        push_req(30'h10, 1'b1, 4'hF, 5'd0, 2'd1);
        chk("full_after4", request_full, 1);
        chk("ovf_before5", overflow_error, 0);
        push_req(30'h10, 1'b1, 4'hF, 5'd0, 2'd3);
        chk("ovf_after5", overflow_error, 1);
        chk("full_after5", request_full, 1);
        push_wd(32'h12345678);
        collect(4, 60);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_d%0d", i), cap_data[i], 32'hDEADBEEF);
            chk($sformatf("ovf_id%0d", i), cap_id[i], 1);
        end
        extra = 0;
        rd_data_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rd_data_valid) extra++;
            @(negedge clk);
        end
        rd_data_ack = 1'b0;
        chk("ovf_dropped", extra, 0);
        chk("ovf_sticky", overflow_error, 1);

        // reset in the middle of a long read burst
        push_req(30'h100, 1'b1, 4'hF, 5'd15, 2'd2);
        collect(4, 30);
        for (int i = 0; i < 4; i++) chk($sformatf("pre_rst_d%0d", i), cap_data[i], i);
        tick(1);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", rd_data_valid, 0);
        tick(2);
        chk("rst_mid_data", rd_data, 0);
        chk("rst_mid_ovf", overflow_error, 0);
        chk("rst_mid_full", request_full, 0);
        rst = 1'b1;
        tick(3);
        chk("post_rst_idle", rd_data_valid, 0);
        push_req(30'h100, 1'b1, 4'hF, 5'd1, 2'd2);
        collect(2, 20);
        chk("post_rst_d0", cap_data[0], 0);
        chk("post_rst_d1", cap_data[1], 1);
        chk("post_rst_id", cap_id[1], 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
